// File: rtl/pl1_rover_pkg.sv
// Shared rover definitions: bridge pair encodings, side FSM states and the
// per-side status payload handed from a ramp side to the top.
package pl1_rover_pkg;

    localparam int unsigned SPEED_W = 3;
    localparam int unsigned PAIR_W  = 2;

    localparam logic [PAIR_W-1:0] DIR_FWD   = 2'b10;
    localparam logic [PAIR_W-1:0] DIR_REV   = 2'b01;
    localparam logic [PAIR_W-1:0] DIR_COAST = 2'b00;
    localparam logic [PAIR_W-1:0] DIR_BRAKE = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DECEL = 2'd1,
        ST_DEAD  = 2'd2
    } side_state_e;

    typedef struct packed {
        logic              busy;
        logic [PAIR_W-1:0] pair;
        logic [SPEED_W-1:0] speed;
    } side_out_t;

endpackage

// File: rtl/pl1_speed_ramp_side.sv
// One bridge side: ramps speed toward target on ticks and forces
// decelerate-to-zero plus coast dead time before any pair change.
module pl1_speed_ramp_side
    import pl1_rover_pkg::*;
#(
    parameter int unsigned DEAD_TICKS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               fault,
    input  logic [SPEED_W-1:0] speed_tgt,
    input  logic [PAIR_W-1:0]  pair_tgt,
    output side_out_t          status
);

    localparam int unsigned CNT_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_TICKS);

    side_state_e        state, state_n;
    logic [SPEED_W-1:0] cur, cur_n;
    logic [PAIR_W-1:0]  pair, pair_n;
    logic [CNT_W-1:0]   dcnt, dcnt_n;
    side_out_t          status_n;

    // Next-state and next-output logic; fault overrides everything.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        pair_n  = pair;
        dcnt_n  = dcnt;
        if (fault) begin
            state_n = ST_DEAD;
            cur_n   = '0;
            pair_n  = DIR_COAST;
            dcnt_n  = DEAD_CNT;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pair_tgt != pair) begin
                        state_n = ST_DECEL;
                    end else if (tick) begin
                        if (cur < speed_tgt) begin
                            cur_n = cur + SPEED_W'(1);
                        end else if (cur > speed_tgt) begin
                            cur_n = cur - SPEED_W'(1);
                        end
                    end
                end
                ST_DECEL: begin
                    if (pair_tgt == pair) begin
                        state_n = ST_RUN;
                    end else if (tick) begin
                        if (cur == '0) begin
                            state_n = ST_DEAD;
                            dcnt_n  = DEAD_CNT;
                        end else begin
                            cur_n = cur - SPEED_W'(1);
                        end
                    end
                end
                ST_DEAD: begin
                    if (tick) begin
                        if (dcnt <= CNT_W'(1)) begin
                            state_n = ST_RUN;
                            cur_n   = '0;
                            pair_n  = pair_tgt;
                            dcnt_n  = '0;
                        end else begin
                            dcnt_n = dcnt - CNT_W'(1);
                        end
                    end
                end
                default: state_n = ST_RUN;
            endcase
        end

        status_n.speed = (state_n == ST_DEAD) ? '0 : cur_n;
        status_n.pair  = (state_n == ST_DEAD) ? DIR_COAST : pair_n;
        status_n.busy  = (state_n != ST_RUN) || (cur_n != speed_tgt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            cur    <= '0;
            pair   <= DIR_COAST;
            dcnt   <= '0;
            status <= '0;
        end else begin
            state  <= state_n;
            cur    <= cur_n;
            pair   <= pair_n;
            dcnt   <= dcnt_n;
            status <= status_n;
        end
    end

endmodule

// File: rtl/pl1_speed_ramp.sv
// Slew-rate and direction-safety stage between motor driver and PWM/H-bridge:
// shared ramp tick generator plus one ramp side per motor.
module pl1_speed_ramp
    import pl1_rover_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1_000_000,
    parameter int unsigned DEAD_TICKS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fault,
    input  logic [SPEED_W-1:0] speed_left_tgt,
    input  logic [SPEED_W-1:0] speed_right_tgt,
    input  logic [3:0]         dir_tgt,
    output logic [SPEED_W-1:0] speed_left,
    output logic [SPEED_W-1:0] speed_right,
    output logic [3:0]         pin_in,
    output logic               ramping
);

    localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;
    side_out_t         left_st;
    side_out_t         right_st;

    assign tick_c = (tick_cnt == TICK_LAST);

    // Free-running ramp tick divider.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    pl1_speed_ramp_side #(.DEAD_TICKS(DEAD_TICKS)) u_left (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick_c),
        .fault     (fault),
        .speed_tgt (speed_left_tgt),
        .pair_tgt  (dir_tgt[1:0]),
        .status    (left_st)
    );

    pl1_speed_ramp_side #(.DEAD_TICKS(DEAD_TICKS)) u_right (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick_c),
        .fault     (fault),
        .speed_tgt (speed_right_tgt),
        .pair_tgt  (dir_tgt[3:2]),
        .status    (right_st)
    );

    // Side status fields are registered; only the busy OR is combinational.
    assign speed_left  = left_st.speed;
    assign speed_right = right_st.speed;
    assign pin_in      = {right_st.pair, left_st.pair};
    assign ramping     = left_st.busy | right_st.busy;

endmodule

// File: tb/tb_pl1_speed_ramp.sv
// Self-checking bench for pl1_speed_ramp: per-cycle behavioural model compare
// plus literal expectations at hand-computed tick boundaries.
module tb_pl1_speed_ramp;

    localparam int TD = 4;
    localparam int DT = 2;

    logic       clock;
    logic       reset;
    logic       fault;
    logic [2:0] speed_left_tgt;
    logic [2:0] speed_right_tgt;
    logic [3:0] dir_tgt;
    logic [2:0] speed_left;
    logic [2:0] speed_right;
    logic [3:0] pin_in;
    logic       ramping;

    int errors = 0;
    int checks = 0;

    pl1_speed_ramp #(.TICK_DIV(TD), .DEAD_TICKS(DT)) dut (
        .clock           (clock),
        .reset           (reset),
        .fault           (fault),
        .speed_left_tgt  (speed_left_tgt),
        .speed_right_tgt (speed_right_tgt),
        .dir_tgt         (dir_tgt),
        .speed_left      (speed_left),
        .speed_right     (speed_right),
        .pin_in          (pin_in),
        .ramping         (ramping)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = driving, 1 = slowing for a new pair, 2 = coasting.
    int since_rst;
    int m_mode[2];
    int m_cur[2];
    int m_pair[2];
    int m_dead[2];
    int e_speed[2];
    int e_pins[2];
    int e_busy[2];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            since_rst = 0;
            for (int s = 0; s < 2; s++) begin
                m_mode[s] = 0; m_cur[s] = 0; m_pair[s] = 0; m_dead[s] = 0;
                e_speed[s] = 0; e_pins[s] = 0; e_busy[s] = 0;
            end
        end else begin
            bit tk;
            tk = ((since_rst % TD) == TD - 1);
            since_rst++;
            for (int s = 0; s < 2; s++) begin
                int tgt;
                int want;
                tgt  = (s == 0) ? int'(speed_left_tgt) : int'(speed_right_tgt);
                want = (s == 0) ? int'(dir_tgt[1:0]) : int'(dir_tgt[3:2]);
                if (fault) begin
                    m_mode[s] = 2; m_cur[s] = 0; m_pair[s] = 0; m_dead[s] = DT;
                end else if (m_mode[s] == 0) begin
                    if (want != m_pair[s]) m_mode[s] = 1;
                    else if (tk && tgt > m_cur[s]) m_cur[s] = m_cur[s] + 1;
                    else if (tk && tgt < m_cur[s]) m_cur[s] = m_cur[s] - 1;
                end else if (m_mode[s] == 1) begin
                    if (want == m_pair[s]) m_mode[s] = 0;
                    else if (tk && m_cur[s] == 0) begin m_mode[s] = 2; m_dead[s] = DT; end
                    else if (tk) m_cur[s] = m_cur[s] - 1;
                end else if (tk) begin
                    m_dead[s] = m_dead[s] - 1;
                    if (m_dead[s] == 0) begin
                        m_mode[s] = 0; m_cur[s] = 0; m_pair[s] = want;
                    end
                end
                e_speed[s] = (m_mode[s] == 2) ? 0 : m_cur[s];
                e_pins[s]  = (m_mode[s] == 2) ? 0 : m_pair[s];
                e_busy[s]  = (m_mode[s] != 0 || m_cur[s] != tgt) ? 1 : 0;
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clock) begin
        chk("cyc speed_left",  int'(speed_left),  e_speed[0]);
        chk("cyc speed_right", int'(speed_right), e_speed[1]);
        chk("cyc pin_in",      int'(pin_in),      e_pins[1] * 4 + e_pins[0]);
        chk("cyc ramping",     int'(ramping),     e_busy[0] | e_busy[1]);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        fault = 1'b0;
        speed_left_tgt  = 3'd7;
        speed_right_tgt = 3'd7;
        dir_tgt = 4'b1010;
        step(3);
        chk("reset pin_in", int'(pin_in), 0);
        chk("reset ramping", int'(ramping), 0);
        reset = 1'b1;

        // Startup: dead time then ramp 1..7
        step(11); chk("start e11 pin_in", int'(pin_in), 4'b0000);
        step(1);  chk("start e12 pin_in", int'(pin_in), 4'b1010);
        step(3);  chk("start e15 speed_left", int'(speed_left), 0);
        step(1);  chk("start e16 speed_left", int'(speed_left), 1);
        step(23); chk("start e39 speed_right", int'(speed_right), 6);
                  chk("start e39 ramping", int'(ramping), 1);
        step(1);  chk("start e40 speed_left", int'(speed_left), 7);
                  chk("start e40 ramping", int'(ramping), 0);

        // Left reversal
        dir_tgt = 4'b1001;
        step(28); chk("rev e68 speed_left", int'(speed_left), 0);
                  chk("rev e68 pin_in", int'(pin_in), 4'b1010);
        step(4);  chk("rev e72 pin_in", int'(pin_in), 4'b1000);
        step(7);  chk("rev e79 pin_in", int'(pin_in), 4'b1000);
        step(1);  chk("rev e80 pin_in", int'(pin_in), 4'b1001);
        step(28); chk("rev e108 speed_left", int'(speed_left), 7);
                  chk("rev e108 speed_right", int'(speed_right), 7);

        // Same-direction slow-down
        speed_left_tgt = 3'd3;
        step(16); chk("slow e124 speed_left", int'(speed_left), 3);
                  chk("slow e124 pin_in", int'(pin_in), 4'b1001);

        // Fault pulse at 5/5
        speed_left_tgt  = 3'd5;
        speed_right_tgt = 3'd5;
        step(8);  chk("flt e132 speed_left", int'(speed_left), 5);
                  chk("flt e132 speed_right", int'(speed_right), 5);
        fault = 1'b1;
        step(1);  fault = 1'b0;
                  chk("flt e133 speed_left", int'(speed_left), 0);
                  chk("flt e133 pin_in", int'(pin_in), 4'b0000);
        step(6);  chk("flt e139 pin_in", int'(pin_in), 4'b0000);
        step(1);  chk("flt e140 pin_in", int'(pin_in), 4'b1001);
        step(20); chk("flt e160 speed_right", int'(speed_right), 5);

        // Reversal aborted during decel at 4
        speed_left_tgt  = 3'd7;
        speed_right_tgt = 3'd7;
        step(8);  dir_tgt = 4'b1010;
        step(12); chk("abort e180 speed_left", int'(speed_left), 4);
        dir_tgt = 4'b1001;
        step(1);  chk("abort e181 speed_left", int'(speed_left), 4);
                  chk("abort e181 pin_in", int'(pin_in), 4'b1001);
        step(11); chk("abort e192 speed_left", int'(speed_left), 7);
                  chk("abort e192 ramping", int'(ramping), 0);

        // Asynchronous reset mid-ramp
        speed_left_tgt = 3'd2;
        step(6);
        #2 reset = 1'b0;
        #1;
        chk("async speed_left", int'(speed_left), 0);
        chk("async speed_right", int'(speed_right), 0);
        chk("async pin_in", int'(pin_in), 0);
        chk("async ramping", int'(ramping), 0);
        @(negedge clock);
        reset = 1'b1;
        step(11); chk("rst2 e11 pin_in", int'(pin_in), 4'b0000);
        step(1);  chk("rst2 e12 pin_in", int'(pin_in), 4'b1001);
        step(40); chk("rst2 e52 speed_left", int'(speed_left), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pl1_speed_ramp.md
# pl1_speed_ramp

Slew-rate and direction-safety stage between the motor driver (target speeds and direction) and the PWM generator and H-bridge pins. It ramps each side's 3-bit speed one step per tick toward its target. It forces a decelerate-to-zero plus coast dead time before any H-bridge direction change. A current-limit fault drops both sides to coast and zero speed immediately, then restarts from zero.

## Interface
Parameters:
- TICK_DIV, 1_000_000: clock cycles per ramp tick (10 ms at 100 MHz); must be ≥ 2.
- DEAD_TICKS, 2: ticks of coast held before applying a new direction; must be ≥ 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low (0 = reset).
- fault  in  1  current-limit fault from the limiter, active-high, sampled on clock.
- speed_left_tgt  in  3  left target speed, 0–7.
- speed_right_tgt  in  3  right target speed, 0–7.
- dir_tgt  in  4  target bridge inputs {IN3,IN2,IN1,IN0}; left pair [1:0], right pair [3:2].
- speed_left  out  3  ramped left speed to PWM.
- speed_right  out  3  ramped right speed to PWM.
- pin_in  out  4  applied bridge inputs, same packing as dir_tgt.
- ramping  out  1  high while either side's output differs from its target or that side is not in RUN.

## Operation
- Tick generator: counter 0..TICK_DIV-1; the tick is a 1-cycle pulse when the count equals TICK_DIV-1, then the count wraps to 0.
- Pair encoding: 10 forward, 01 reverse, 00 coast, 11 brake. Any difference between a target pair and the applied pair is a direction change.
- Each side has an independent FSM with states RUN, DECEL, DEAD. Per-side registers are cur (3 bits), applied pair (2 bits) and dead count.
- RUN:
  - pins = applied pair; speed = cur.
  - On a tick: cur moves ±1 toward target; no overshoot, no change when equal.
  - Direction mismatch: go to DECEL on the next cycle, without waiting for a tick.
- DECEL:
  - pins = applied pair; speed = cur.
  - On a tick: if cur = 0, go to DEAD with count = DEAD_TICKS; otherwise cur − 1.
  - If the target pair equals the applied pair again, return to RUN on the next cycle and keep cur.
- DEAD:
  - pins = 00; speed = 0.
  - Each tick decrements the count.
  - The tick that takes the count to 0 latches the current target pair into the applied pair and enters RUN with cur = 0.
- Fault:
  - Any cycle with fault = 1 forces both sides to DEAD with count = DEAD_TICKS, cur = 0 and applied pair = 00, visible on the next cycle.
  - The count reloads every cycle while fault stays high.
  - Fault overrides every other transition on the same cycle.
- Target pair changes during DEAD: no effect until the exit tick; the value present on that tick is applied.
- The ramp is saturating, with no arithmetic wrap; width rules keep cur in 0..7.

## Timing
- Reset values: speed_left = 0, speed_right = 0, pin_in = 0000, ramping = 0. Both FSMs reset to RUN with applied pair = 00; tick counter = 0.
- All outputs are registered. A speed step appears 1 cycle after its tick.
- Fault-to-zero latency: 1 cycle.
- Minimum reversal time from speed s: s ticks of DECEL, plus 1 tick to leave DECEL, plus DEAD_TICKS ticks. Each tick boundary is subject to tick phase.
- ramping is combinational from registered state; it is glitch-free because its sources are registered.

## Structure
- Shared package pl1_rover_pkg holds:
  - pair encodings as localparams (DIR_FWD, DIR_REV, DIR_COAST, DIR_BRAKE);
  - the side-FSM state enum;
  - the SPEED_W = 3 constant.
- Sub-module pl1_speed_ramp_side holds one side's FSM, cur, applied pair and dead count. It is instantiated twice. Tick generator and ramping OR stay in the top.

## Test plan
All runs use TICK_DIV = 4 and DEAD_TICKS = 2.
- Release reset with dir_tgt = 1010 and both targets 7:
  - pin_in = 0000 until the 3rd tick, then 1010;
  - speeds rise 1..7 on ticks 4–10;
  - ramping falls after tick 10.
- Steady 1010 at 7/7, then dir_tgt = 1001:
  - left speed falls 6..0 over 7 ticks, with pins[1:0] = 10 during the fall;
  - then 00 for 2 ticks, then 01 and a ramp from 0;
  - right side stays 10 at 7 throughout.
- Steady at 7, left target changed to 3 with the same direction: left goes 6, 5, 4, 3 on consecutive ticks; pins unchanged; no DEAD.
- One-cycle fault pulse at speed 5/5 with pins 1010:
  - next cycle speeds = 0 and pin_in = 0000;
  - 2 ticks after fault drops, pin_in = 1010;
  - speeds ramp 1..5.
- Left reversal requested, then restored during DECEL at cur = 4: left returns to RUN at 4, ramps back to 7, and never shows pins 00.
- reset driven low mid-ramp (asynchronously, between clock edges): all outputs 0 immediately; the tick counter restarts from 0 after release.
